adder_share_arbiter: RTL
========================

// Module: adder_share_arbiter
// PURPOSE
//   Shares one WIDTH-bit adder datapath between NREQ requesters in round-robin order.
//   Each requester presents an operand pair under a valid/ready handshake.
//   The block grants one requester per cycle, registers sum and carry, and returns them with
//   the winner's id through a single-entry output stage under valid/ready.
//   It sits between the pin-level input decode and the output mux in the top-level wrapper.
// PARAMETERS
//   NREQ   4   number of requesters, >=2, power of two
//   WIDTH  8   operand/sum width in bits
//   CNTW   16  width of the transaction counter
// PORTS
//   clk        in   1            system clock, all state on rising edge
//   rst        in   1            asynchronous, active-high reset
//   ena        in   1            1 = new grants allowed; 0 = no new accepts (output stage still drains)
//   req_valid  in   NREQ         per-requester operands valid
//   req_ready  out  NREQ         per-requester accept; one-hot or zero
//   req_a      in   NREQ*WIDTH   operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      in   NREQ*WIDTH   operand B, same packing
//   rsp_valid  out  1            result held in output stage
//   rsp_ready  in   1            consumer accepts result
//   rsp_id     out  $clog2(NREQ) index of requester that produced result
//   rsp_sum    out  WIDTH        (a+b) mod 2**WIDTH
//   rsp_carry  out  1            bit WIDTH of a+b
//   txn_count  out  CNTW         number of accepted requests, wraps at 2**CNTW
// BEHAVIOUR
//   - Reset (async assert, sync release): rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_carry=0,
//     txn_count=0, rr_last=NREQ-1 so requester 0 has top priority after reset.
//   - can_accept = ena & (~rsp_valid | rsp_ready). Full throughput: drain and refill in the same cycle.
//   - Grant is combinational. Among req_valid bits, pick the first index searching
//     rr_last+1, rr_last+2, ... mod NREQ.
//     req_ready[g] = can_accept & req_valid[g]; all other req_ready bits are 0.
//   - req_ready must not depend on rsp_valid alone when rsp_ready=1.
//     No combinational path from req_ready back into req_valid.
//   - On a handshake (req_valid[g] & req_ready[g]), at the next edge:
//     - {rsp_carry,rsp_sum} <= a_g + b_g, computed at WIDTH+1 bits, unsigned.
//     - rsp_id <= g, rsp_valid <= 1, rr_last <= g.
//     - txn_count <= txn_count+1, wrapping.
//   - Latency: handshake in cycle N gives the result visible in cycle N+1.
//   - Output stage, two-state FSM:
//     - EMPTY (rsp_valid=0) -> FULL on accept.
//     - FULL -> EMPTY on rsp_ready with no new accept.
//     - FULL -> FULL on rsp_ready plus a new accept; outputs are overwritten with the new result.
//   - While FULL and rsp_ready=0: rsp_* held stable; no req_ready asserted.
//   - ena=0: no accepts; rr_last frozen; a FULL stage still drains on rsp_ready.
//   - Single active requester gets every cycle (no forced idle).
//     All NREQ active gives a strict rotation 0,1,..,NREQ-1,0.
//   - Requester dropping req_valid without handshake: legal; it simply loses the grant.
//   - Reset mid-transaction: held result is discarded, no rsp handshake is emitted; the pointer restarts.
// STRUCTURE
//   - Shared package adder_share_pkg holds:
//     - localparams NREQ_DEF=4, WIDTH_DEF=8.
//     - function idx_w(n) = $clog2(n).
//     - typedef of the output stage state {EMPTY, FULL}.
//   - Sub-module rr_arbiter holds the pure grant logic. Ports: req[NREQ], last[idx_w], gnt_oh[NREQ],
//     gnt_idx, any. It is combinational and reused by other shared-resource blocks.
//   - Top holds the operand mux, the WIDTH+1 adder, the output register, rr_last and txn_count.
// TESTING
//   1. Reset, single request. Assert and release rst; valid[0]=1, a0=8'h12, b0=8'h34.
//      -> ready[0]=1 in cycle 0. Cycle 1: rsp_valid=1, id=0, sum=8'h46, carry=0, txn_count=1.
//   2. Carry. a2=8'hF0, b2=8'h20 -> sum=8'h10, carry=1, id=2.
//   3. Rotation. All 4 valid, rsp_ready=1 for 8 cycles -> ids 0,1,2,3,0,1,2,3; one result per cycle;
//      txn_count=8.
//   4. Backpressure. rsp_ready=0 for 3 cycles while FULL -> req_ready=0; rsp_* stable.
//      rsp_ready=1 -> next requester accepted the same cycle.
//   5. ena gating. ena=0 with valid=4'b1111 -> no ready, txn_count unchanged.
//      A pending result still drains on rsp_ready.
//   6. Async reset mid-stream. Assert rst while FULL, between edges -> rsp_valid=0 immediately.
//      After release, first grant goes to id 0.

Source files
------------

// File: rtl/adder_share_arbiter_pkg.sv
// Shared definitions for the round-robin adder-sharing block and its grant logic.
package adder_share_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 8;
    localparam int CNTW_DEF  = 16;

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Requester and result handshake bundle for adder_share_arbiter.
interface adder_share_arbiter_if #(
    parameter int NREQ  = adder_share_pkg::NREQ_DEF,
    parameter int WIDTH = adder_share_pkg::WIDTH_DEF,
    parameter int CNTW  = adder_share_pkg::CNTW_DEF
);
    localparam int IW = adder_share_pkg::idx_w(NREQ);

    logic                    ena;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*WIDTH-1:0]   req_a;
    logic [NREQ*WIDTH-1:0]   req_b;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [IW-1:0]           rsp_id;
    logic [WIDTH-1:0]        rsp_sum;
    logic                    rsp_carry;
    logic [CNTW-1:0]         txn_count;

    modport master (
        output ena, req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, txn_count
    );

    modport slave (
        input  ena, req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, txn_count
    );

endinterface

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first requester after 'last', wrapping modulo NREQ.
module rr_arbiter
    import adder_share_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]          req,
    input  logic [idx_w(NREQ)-1:0]   last,
    output logic [NREQ-1:0]          gnt_oh,
    output logic [idx_w(NREQ)-1:0]   gnt_idx,
    output logic                     any
);
    localparam int IW = idx_w(NREQ);

    logic [IW-1:0] cand;

    // NREQ is a power of two, so the IW-bit add wraps the search for free.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = last + IW'(k);
            if (!any && req[cand]) begin
                any     = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt_oh = any ? (NREQ'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// One WIDTH-bit adder shared round-robin among NREQ requesters, with a
// single-entry registered result stage that can drain and refill every cycle.
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNTW  = CNTW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    adder_share_arbiter_if.slave bus
);
    localparam int IW = idx_w(NREQ);

    out_state_e       state_q, state_d;
    logic [IW-1:0]    rr_last_q, rr_last_d;
    logic [IW-1:0]    rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CNTW-1:0]  txn_count_q, txn_count_d;

    logic [NREQ-1:0]  gnt_oh;
    logic [IW-1:0]    gnt_idx;
    logic             any_req;
    logic             can_accept;
    logic             accept;
    logic [WIDTH-1:0] a_sel, b_sel;
    logic [WIDTH:0]   sum_full;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (bus.req_valid),
        .last    (rr_last_q),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx),
        .any     (any_req)
    );

    // A full stage being drained this cycle frees the slot for the next winner.
    assign can_accept    = bus.ena & ((state_q == EMPTY) | bus.rsp_ready);
    assign accept        = can_accept & any_req;
    assign bus.req_ready = {NREQ{can_accept}} & gnt_oh;

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IW'(i)) begin
                a_sel = bus.req_a[i*WIDTH +: WIDTH];
                b_sel = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
        sum_full = {1'b0, a_sel} + {1'b0, b_sel};
    end

    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        rsp_id_d    = rsp_id_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        txn_count_d = txn_count_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (!accept && bus.rsp_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (accept) begin
            rr_last_d   = gnt_idx;
            rsp_id_d    = gnt_idx;
            sum_d       = sum_full[WIDTH-1:0];
            carry_d     = sum_full[WIDTH];
            txn_count_d = txn_count_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            rr_last_q   <= IW'(NREQ - 1);
            rsp_id_q    <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            txn_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            rsp_id_q    <= rsp_id_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            txn_count_q <= txn_count_d;
        end
    end

    assign bus.rsp_valid = (state_q == FULL);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_carry = carry_q;
    assign bus.txn_count = txn_count_q;

endmodule
